alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Initiator side of the ALU operation interface: accepts one operation at a time from the instruction sequencer over a valid/ready request channel.
- Drives the ALU command, state and operand lines, waits for the ALU next_state completion pulse, then captures dst/dst_h.
- Returns the captured result over a valid/ready response channel.
- Adds a completion timeout and pre-issue divide-by-zero trapping, so the sequencer never hangs on the ALU.

Parameters:
- DATA_W, 32, operand/result width (matches DATA_SIZE).
- STATE_W, 8, width of the ALU state bus (matches STATE_SIZE).
- ALU_BEGIN_CODE, 8'h10, state value that starts an ALU operation.
- ALU_IDLE_CODE, 8'h00, state value driven whenever no operation is being started.
- DIV_CODE, 4'h4, cmd_code (command[31:28]) of the divide operation.
- TIMEOUT, 16, maximum WAIT cycles before abort; legal range 1..65535.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid is also high.
- req_command  in  32  instruction word; bits [31:28] are the cmd_code.
- req_src0  in  DATA_W  first operand.
- req_src1  in  DATA_W  second operand.
- alu_command  out  32  command to the ALU.
- alu_state  out  STATE_W  state to the ALU.
- alu_src0  out  DATA_W  operand 0 to the ALU.
- alu_src1  out  DATA_W  operand 1 to the ALU.
- alu_next_state  in  1  ALU completion; only logic 1 counts as done (0, X and Z do not).
- alu_dst  in  DATA_W  result low word.
- alu_dst_h  in  DATA_W  result high word / remainder.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_dst  out  DATA_W  captured low word.
- res_dst_h  out  DATA_W  captured high word.
- res_err  out  1  1 = timeout or divide-by-zero; both data words are 0.
- res_err_code  out  2  00 none, 01 timeout, 10 divide-by-zero.

Behaviour:
- Reset: synchronous, active-high, on the rising edge of clk; overrides every other input that cycle, including mid-operation.
  - FSM goes to IDLE and the timeout counter clears.
  - req_ready=1 (it follows the IDLE state); res_valid=0.
  - res_dst=0, res_dst_h=0, res_err=0, res_err_code=00.
  - alu_state=ALU_IDLE_CODE, alu_command=0, alu_src0=0, alu_src1=0.
  - An ALU completion that arrives after reset is ignored.
- All outputs are registered.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1; all other states hold req_ready=0.
  - On req_valid the request is latched into alu_command, alu_src0 and alu_src1.
  - If cmd_code==DIV_CODE and req_src1==0, go directly to RESP with res_err=1, code 10, data 0; the ALU is not started.
  - Otherwise go to ISSUE.
- ISSUE:
  - Lasts exactly one cycle with alu_state=ALU_BEGIN_CODE.
  - Then go to WAIT and return alu_state to ALU_IDLE_CODE.
- WAIT:
  - alu_command, alu_src0 and alu_src1 stay stable.
  - The counter increments each cycle.
  - If alu_next_state==1 this cycle, capture alu_dst into res_dst and alu_dst_h into res_dst_h, set res_err=0, go to RESP.
  - Else, if the counter reaches TIMEOUT, set res_err=1, code 01, data 0, go to RESP.
  - If completion and timeout occur in the same cycle, completion wins.
- RESP:
  - res_valid=1; result outputs are held until res_valid & res_ready.
  - On that handshake go to IDLE, clear res_valid and clear the counter.
  - No back-to-back bypass: a new request is only accepted in IDLE, the cycle after the handshake.
- alu_next_state outside WAIT is ignored; it neither causes a capture nor changes state.
- Nominal latency, with request accepted at edge N:
  - ISSUE occupies cycle N+1.
  - The ALU registers next_state during N+2, so capture happens at edge N+2→N+3.
  - res_valid=1 from cycle N+3.
  - Throughput is at most 1 operation per 4 cycles.
- Width rule: result words pass through unmodified; no sign or width manipulation.

Test Plan:
- ADD: req_command=32'h1000_0000, src0=5, src1=7, ALU model answers dst=12, dst_h=0 after one cycle → res_valid at N+3, res_dst=12, res_dst_h=0, res_err=0.
- DIV by zero: cmd_code=DIV_CODE, src1=0 → alu_state never equals ALU_BEGIN_CODE; res_valid=1 with res_err=1, res_err_code=10, data 0.
- Timeout: TIMEOUT=16, ALU model never asserts next_state (holds it at Z) → res_err=1, code 01, res_valid rising exactly 16 WAIT cycles after ISSUE.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid → res_dst/res_dst_h/res_valid stable; req_ready=0 throughout; a second req_valid is not accepted until the cycle after the handshake.
- Reset mid-WAIT: assert rst for 1 cycle during WAIT, ALU model then pulses next_state=1 → all outputs return to reset values, res_valid stays 0, req_ready=1.
- Completion on the last cycle: TIMEOUT=4, next_state=1 on the 4th WAIT cycle → normal capture, res_err=0.

Source files
------------

// File: rtl/alu_issue.sv
// Issue side of the ALU operation interface: takes one request, drives the ALU,
// waits for completion (with timeout and divide-by-zero trap), returns the result.
module alu_issue #(
   parameter int unsigned         DATA_W         = 32,
   parameter int unsigned         STATE_W        = 8,
   parameter logic [STATE_W-1:0]  ALU_BEGIN_CODE = 8'h10,
   parameter logic [STATE_W-1:0]  ALU_IDLE_CODE  = 8'h00,
   parameter logic [3:0]          DIV_CODE       = 4'h4,
   parameter int unsigned         TIMEOUT        = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [31:0]        req_command,
   input  logic [DATA_W-1:0]  req_src0,
   input  logic [DATA_W-1:0]  req_src1,
   output logic [31:0]        alu_command,
   output logic [STATE_W-1:0] alu_state,
   output logic [DATA_W-1:0]  alu_src0,
   output logic [DATA_W-1:0]  alu_src1,
   input  logic               alu_next_state,
   input  logic [DATA_W-1:0]  alu_dst,
   input  logic [DATA_W-1:0]  alu_dst_h,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [DATA_W-1:0]  res_dst,
   output logic [DATA_W-1:0]  res_dst_h,
   output logic               res_err,
   output logic [1:0]         res_err_code
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   localparam logic [16:0] TO_LIM = 17'(TIMEOUT);

   state_t      state;
   logic [15:0] cnt;
   logic [16:0] cnt_inc;

   always_comb begin
      cnt_inc = {1'b0, cnt} + 17'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         req_ready    <= 1'b1;
         res_valid    <= 1'b0;
         res_dst      <= '0;
         res_dst_h    <= '0;
         res_err      <= 1'b0;
         res_err_code <= 2'b00;
         alu_state    <= ALU_IDLE_CODE;
         alu_command  <= '0;
         alu_src0     <= '0;
         alu_src1     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  alu_command <= req_command;
                  alu_src0    <= req_src0;
                  alu_src1    <= req_src1;
                  req_ready   <= 1'b0;
                  // Divide-by-zero is answered locally; the ALU is never started.
                  if (req_command[31:28] == DIV_CODE && req_src1 == '0) begin
                     state        <= S_RESP;
                     res_valid    <= 1'b1;
                     res_err      <= 1'b1;
                     res_err_code <= 2'b10;
                     res_dst      <= '0;
                     res_dst_h    <= '0;
                  end else begin
                     state     <= S_ISSUE;
                     alu_state <= ALU_BEGIN_CODE;
                  end
               end
            end
            S_ISSUE: begin
               alu_state <= ALU_IDLE_CODE;
               cnt       <= '0;
               state     <= S_WAIT;
            end
            S_WAIT: begin
               cnt <= cnt_inc[15:0];
               // Completion takes priority over a timeout landing in the same cycle.
               if (alu_next_state) begin
                  res_dst      <= alu_dst;
                  res_dst_h    <= alu_dst_h;
                  res_err      <= 1'b0;
                  res_err_code <= 2'b00;
                  res_valid    <= 1'b1;
                  state        <= S_RESP;
               end else if (cnt_inc == TO_LIM) begin
                  res_dst      <= '0;
                  res_dst_h    <= '0;
                  res_err      <= 1'b1;
                  res_err_code <= 2'b01;
                  res_valid    <= 1'b1;
                  state        <= S_RESP;
               end
            end
            S_RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  req_ready <= 1'b1;
                  cnt       <= '0;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state     <= S_IDLE;
               req_ready <= 1'b1;
               res_valid <= 1'b0;
               alu_state <= ALU_IDLE_CODE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed requests push expected results,
// a monitor pops and compares on every response handshake.
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_command = '0;
   logic [31:0] req_src0 = '0;
   logic [31:0] req_src1 = '0;
   logic [31:0] alu_command;
   logic [7:0]  alu_state;
   logic [31:0] alu_src0;
   logic [31:0] alu_src1;
   logic        alu_next_state;
   logic [31:0] alu_dst = '0;
   logic [31:0] alu_dst_h = '0;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic [31:0] res_dst;
   logic [31:0] res_dst_h;
   logic        res_err;
   logic [1:0]  res_err_code;

   alu_issue #(
      .DATA_W(32), .STATE_W(8), .ALU_BEGIN_CODE(8'h10), .ALU_IDLE_CODE(8'h00),
      .DIV_CODE(4'h4), .TIMEOUT(16)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_command(req_command),
      .req_src0(req_src0), .req_src1(req_src1),
      .alu_command(alu_command), .alu_state(alu_state),
      .alu_src0(alu_src0), .alu_src1(alu_src1),
      .alu_next_state(alu_next_state), .alu_dst(alu_dst), .alu_dst_h(alu_dst_h),
      .res_valid(res_valid), .res_ready(res_ready), .res_dst(res_dst),
      .res_dst_h(res_dst_h), .res_err(res_err), .res_err_code(res_err_code)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   typedef struct {
      int          acc;
      int          lat;
      logic [31:0] dst;
      logic [31:0] dsth;
      logic        err;
      logic [1:0]  code;
   } exp_t;
   exp_t q[$];

   // ALU model: replies reply_at cycles into WAIT (0 = never replies)
   int          reply_at = 0;
   logic [31:0] r_dst = '0, r_dsth = '0;
   logic [31:0] exp_cmd = '0, exp_s0 = '0, exp_s1 = '0;
   logic        ns_drv = 1'b0;
   logic        stray = 1'b0;
   int          wcnt = 0;
   bit          active = 1'b0;
   int          begin_seen = 0;

   assign alu_next_state = ns_drv | stray;

   always @(negedge clk) begin
      ns_drv    = 1'b0;
      alu_dst   = 32'hBAD0_BAD0;
      alu_dst_h = 32'hBAD1_BAD1;
      if (active) begin
         wcnt++;
         if (wcnt == reply_at) begin
            ns_drv    = 1'b1;
            alu_dst   = r_dst;
            alu_dst_h = r_dsth;
            active    = 1'b0;
         end else if (wcnt > 40) begin
            active = 1'b0;
         end
      end
      if (alu_state == 8'h10) begin
         active = 1'b1;
         wcnt   = 0;
         begin_seen++;
         chk("issue_cmd", {32'd0, alu_command}, {32'd0, exp_cmd});
         chk("issue_src", {alu_src0, alu_src1}, {exp_s0, exp_s1});
      end
   end

   // Monitor: latency and result compared on each handshake
   logic prev_valid = 1'b0;
   int   rise_cyc = 0;
   always @(negedge clk) begin
      exp_t e;
      #1;
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (res_valid && !prev_valid) rise_cyc = cyc;
         if (res_valid && res_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_res", 64'd1, 64'd0);
            end else begin
               e = q.pop_front();
               chk("res_dst", {32'd0, res_dst}, {32'd0, e.dst});
               chk("res_dst_h", {32'd0, res_dst_h}, {32'd0, e.dsth});
               chk("res_err", {63'd0, res_err}, {63'd0, e.err});
               chk("res_err_code", {62'd0, res_err_code}, {62'd0, e.code});
               chk("latency", 64'(rise_cyc - e.acc), 64'(e.lat));
            end
         end
         prev_valid = res_valid;
      end
   end

   task automatic send(input logic [31:0] cmd, input logic [31:0] s0, input logic [31:0] s1,
                       input int ra, input logic [31:0] rd, input logic [31:0] rdh,
                       input int lat, input logic [31:0] ed, input logic [31:0] edh,
                       input logic eerr, input logic [1:0] ecode);
      exp_t e;
      int   n;
      reply_at = ra; r_dst = rd; r_dsth = rdh;
      exp_cmd = cmd; exp_s0 = s0; exp_s1 = s1;
      @(negedge clk);
      req_valid = 1'b1; req_command = cmd; req_src0 = s0; req_src1 = s1;
      #1;
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk); #1; n++;
      end
      if (!req_ready) begin
         chk("req_accept_timeout", 64'd0, 64'd1);
      end else begin
         e.acc = cyc + 1; e.lat = lat; e.dst = ed; e.dsth = edh; e.err = eerr; e.code = ecode;
         q.push_back(e);
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      #1;
      while ((q.size() != 0 || res_valid) && n < 200) begin
         @(negedge clk); #1; n++;
      end
      chk("drain_timeout", {63'd0, (q.size() != 0 || res_valid)}, 64'd0);
   endtask

   int bs;

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
      chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
      chk("rst_res_data", {res_dst, res_dst_h}, 64'd0);
      chk("rst_res_err", {61'd0, res_err, res_err_code}, 64'd0);
      chk("rst_alu_state", {56'd0, alu_state}, 64'd0);
      chk("rst_alu_cmd", {32'd0, alu_command}, 64'd0);
      chk("rst_alu_src", {alu_src0, alu_src1}, 64'd0);

      // completion pulse in IDLE must be ignored
      @(negedge clk); stray = 1'b1;
      @(negedge clk); stray = 1'b0;
      #1;
      chk("stray_res_valid", {63'd0, res_valid}, 64'd0);
      chk("stray_req_ready", {63'd0, req_ready}, 64'd1);

      send(32'h1000_0000, 32'd5, 32'd7, 1, 32'd12, 32'd0, 2, 32'd12, 32'd0, 1'b0, 2'b00);
      drain();
      send(32'h2000_0003, 32'hFFFF_FFFF, 32'd1, 2, 32'h8000_0001, 32'hDEAD_BEEF,
           3, 32'h8000_0001, 32'hDEAD_BEEF, 1'b0, 2'b00);
      drain();

      bs = begin_seen;
      send(32'h4000_0000, 32'd100, 32'd0, 1, 32'd1, 32'd1, 0, 32'd0, 32'd0, 1'b1, 2'b10);
      drain();
      chk("div0_no_begin", 64'(begin_seen - bs), 64'd0);

      send(32'h4000_0000, 32'd17, 32'd5, 1, 32'd3, 32'd2, 2, 32'd3, 32'd2, 1'b0, 2'b00);
      drain();
      send(32'h5000_0000, 32'd9, 32'd0, 1, 32'd7, 32'd0, 2, 32'd7, 32'd0, 1'b0, 2'b00);
      drain();

      // timeout: 16 WAIT cycles, garbage on alu_dst must not leak
      send(32'h3000_0000, 32'd1, 32'd2, 0, 32'd0, 32'd0, 17, 32'd0, 32'd0, 1'b1, 2'b01);
      drain();
      // completion on the 16th (last) WAIT cycle wins
      send(32'h3000_0000, 32'd9, 32'd9, 16, 32'h51, 32'd1, 17, 32'h51, 32'd1, 1'b0, 2'b00);
      drain();

      // backpressure with a second request waiting
      res_ready = 1'b0;
      send(32'h1000_0000, 32'd40, 32'd2, 1, 32'd42, 32'd0, 2, 32'd42, 32'd0, 1'b0, 2'b00);
      for (int i = 0; i < 20 && !res_valid; i++) begin
         @(negedge clk); #1;
      end
      req_valid = 1'b1; req_command = 32'h1000_0000; req_src0 = 32'd1; req_src1 = 32'd1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         chk("bp_hold", {30'd0, res_valid, req_ready, res_dst}, {30'd0, 1'b1, 1'b0, 32'd42});
      end
      @(negedge clk); res_ready = 1'b1;
      #1;
      chk("bp_no_accept", {63'd0, req_ready}, 64'd0);
      send(32'h1000_0000, 32'd1, 32'd1, 1, 32'd2, 32'd0, 2, 32'd2, 32'd0, 1'b0, 2'b00);
      drain();

      // reset during WAIT; the late completion must be ignored
      send(32'h1000_0000, 32'd3, 32'd3, 3, 32'd6, 32'd0, 2, 32'd6, 32'd0, 1'b0, 2'b00);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      q.delete();
      #1;
      chk("mid_rst_req_ready", {63'd0, req_ready}, 64'd1);
      chk("mid_rst_res_valid", {63'd0, res_valid}, 64'd0);
      chk("mid_rst_alu", {24'd0, alu_state, alu_command}, 64'd0);
      repeat (4) @(negedge clk);
      #1;
      chk("post_rst_idle", {30'd0, res_valid, req_ready, res_dst}, {30'd0, 1'b0, 1'b1, 32'd0});

      send(32'h1000_0000, 32'd20, 32'd22, 1, 32'd42, 32'd0, 2, 32'd42, 32'd0, 1'b0, 2'b00);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
